cmp_eq_rr_arbiter: RTL and testbench
====================================

# cmp_eq_rr_arbiter

Round-robin arbiter and sequencer that shares one 32-bit equality comparator among N requesters. It grants one requester at a time, latches that requester's operand pair, and registers the equality result. The result is returned over a valid/ready handshake tagged with the requester index. The block sits between the requesting agents and the single comparator datapath, and also keeps a saturating count of accepted matches.

## Interface

Parameters:
- N, 4 — number of requesters (2..16).
- W, 32 — operand width.
- CNT_W, 16 — match counter width.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge.
- rst_n  in  1  — asynchronous active-low reset.
- req  in  N  — per-requester request; held high with operands stable until the matching ack.
- a_in  in  N*W  — operand A; requester i occupies bits [i*W +: W].
- b_in  in  N*W  — operand B, same packing as a_in.
- ack  out  N  — one-hot, one-cycle pulse; operands of that requester were captured.
- res_valid  out  1  — result available.
- res_ready  in  1  — consumer accepts the result.
- res_eq  out  1  — 1 when the captured A equals the captured B.
- res_id  out  clog2(N)  — index of the requester that owns the result.
- busy  out  1  — high in any state other than IDLE.
- match_cnt  out  CNT_W  — count of accepted results with res_eq=1; saturates at all-ones.

## Operation

- Registered state:
  - FSM: IDLE, CMP, HOLD.
  - Operand registers: a_r, b_r.
  - id_r.
  - Round-robin pointer ptr, holding the last granted index.
- Grant selection: the first i with req[i]=1, searching ptr+1, ptr+2, … with wrap mod N.
- IDLE:
  - If |req: capture a_r, b_r and id_r from the selected winner.
  - ack <= onehot(winner); ptr <= winner; go to CMP.
  - Otherwise stay in IDLE.
- CMP:
  - res_eq <= (a_r == b_r), compared over the full W bits.
  - res_id <= id_r; res_valid <= 1; go to HOLD.
- HOLD:
  - res_valid stays high. res_eq and res_id are stable until accepted.
  - When res_ready=1 the result is accepted:
    - res_valid <= 0.
    - match_cnt increments if res_eq=1 and it is not saturated.
  - If the result is accepted and |req in the same cycle: perform the IDLE grant actions in that cycle (capture, ack, ptr update) and go directly to CMP.
  - If the result is accepted and no req: go to IDLE.
  - If res_ready=0: stay in HOLD; no grant is issued.
- ack is 0 in every cycle except the one following a grant edge.
- Requester rule: drop req, or change operands, no earlier than the edge after ack is seen. The block never samples req in CMP, so a held-over req cannot cause a double grant.
- Requests arriving during CMP or HOLD wait; there is no queueing beyond the req level.
- busy = (state != IDLE).

## Timing

- Reset values (asynchronous, rst_n=0):
  - State IDLE; ptr=N-1, so requester 0 has first priority.
  - ack=0, res_valid=0, res_eq=0, res_id=0, busy=0, match_cnt=0.
  - a_r, b_r and id_r cleared.
- Reset mid-operation: the in-flight transaction is discarded. No ack or res_valid appears for it after reset deasserts.
- Latency, with req sampled at edge E0 in IDLE:
  - ack high from E0 to E1.
  - res_valid high from E1.
  - Earliest acceptance at E2.
- Throughput under continuous requests with res_ready=1: one grant every 2 cycles (HOLD→CMP back-to-back).
- Backpressure: res_valid, res_eq and res_id hold for any number of cycles with res_ready=0.
- Simultaneous requests: exactly one ack bit per grant; the pointer rotation guarantees each waiting requester is served within N grants.
- Counter: updates only on the acceptance edge. At all-ones a further match leaves the value unchanged.

## Test plan

- Single request:
  - Stimulus: req=0001, a=b=0xDEADBEEF, res_ready=1.
  - Response: ack=0001 one cycle after the edge; res_valid the next cycle with res_eq=1, res_id=0; match_cnt=1.
- Mismatch in the top bit:
  - Stimulus: req=0100, a=0x80000000, b=0x00000000.
  - Response: res_eq=0, res_id=2; match_cnt unchanged.
- All-request fairness:
  - Stimulus: req=1111 held, each requester dropping its req after its ack, res_ready=1.
  - Response: grant order 0,1,2,3; consecutive grants 2 cycles apart.
- Rotation:
  - Stimulus: after a grant to 2, raise req=1001.
  - Response: requester 3 is granted before requester 0.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles while req=0010 is pending.
  - Response: the result stays stable; no ack is issued until the acceptance cycle, and ack=0010 follows that cycle.
- Reset and saturation:
  - Stimulus A: assert rst_n=0 during CMP. Response: all outputs return to 0 immediately, and no res_valid appears afterwards.
  - Stimulus B: CNT_W=2 and 5 accepted matches. Response: match_cnt=3.

Source files
------------

// File: rtl/cmp_eq_rr_arbiter.sv
// Round-robin arbiter sharing one W-bit equality comparator among N requesters; ack one cycle after grant,
// result valid one cycle after ack; result holds under res_ready=0 and no new grant is issued meanwhile.
module cmp_eq_rr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int CNT_W = 16,
  localparam int IW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  output logic [N-1:0]     ack,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_eq,
  output logic [IW-1:0]    res_id,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {IDLE, CMP, HOLD} state_t;

  state_t           state_q;
  logic [W-1:0]     a_q, b_q;
  logic [IW-1:0]    id_q, ptr_q, rid_q;
  logic [N-1:0]     ack_q;
  logic             vld_q, eq_q;
  logic [CNT_W-1:0] cnt_q;

  logic             found_d;
  logic [IW-1:0]    win_d;
  logic [N-1:0]     oh_d;
  logic [W-1:0]     a_d, b_d;
  logic             grant_d;

  // Search starts one past the last winner so every waiter is reached within N grants.
  always_comb begin
    int idx;
    found_d = 1'b0;
    win_d   = '0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found_d && req[IW'(idx)]) begin
        found_d = 1'b1;
        win_d   = IW'(idx);
      end
    end
  end

  always_comb begin
    oh_d = '0;
    a_d  = '0;
    b_d  = '0;
    for (int i = 0; i < N; i++) begin
      if (win_d == IW'(i)) begin
        oh_d[i] = 1'b1;
        a_d     = a_in[i*W +: W];
        b_d     = b_in[i*W +: W];
      end
    end
  end

  // A grant may fire from IDLE or on the very edge that retires the held result.
  assign grant_d = found_d && ((state_q == IDLE) || ((state_q == HOLD) && res_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      ptr_q   <= IW'(N-1);
      ack_q   <= '0;
      vld_q   <= 1'b0;
      eq_q    <= 1'b0;
      rid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ack_q <= '0;
      if (grant_d) begin
        a_q   <= a_d;
        b_q   <= b_d;
        id_q  <= win_d;
        ack_q <= oh_d;
        ptr_q <= win_d;
      end
      case (state_q)
        IDLE: if (grant_d) state_q <= CMP;
        CMP: begin
          eq_q    <= (a_q == b_q);
          rid_q   <= id_q;
          vld_q   <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            vld_q <= 1'b0;
            if (eq_q && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
            state_q <= grant_d ? CMP : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign res_valid = vld_q;
  assign res_eq    = eq_q;
  assign res_id    = rid_q;
  assign busy      = (state_q != IDLE);
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_cmp_eq_rr_arbiter.sv
// Scoreboard bench for cmp_eq_rr_arbiter: directed requests push expected {eq,id}; a negedge monitor pops on accept.
module tb_cmp_eq_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req;
  logic [W-1:0]   a_op [N];
  logic [W-1:0]   b_op [N];
  logic [N*W-1:0] a_in, b_in;
  logic           res_ready;

  logic [N-1:0]   ack;
  logic           res_valid, res_eq, busy;
  logic [1:0]     res_id;
  logic [15:0]    match_cnt;

  logic [N-1:0]   s_ack;
  logic           s_res_valid, s_res_eq, s_busy;
  logic [1:0]     s_res_id;
  logic [1:0]     s_match_cnt;

  assign a_in = {a_op[3], a_op[2], a_op[1], a_op[0]};
  assign b_in = {b_op[3], b_op[2], b_op[1], b_op[0]};

  cmp_eq_rr_arbiter #(.N(N), .W(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .ack(ack),
    .res_valid(res_valid), .res_ready(res_ready), .res_eq(res_eq), .res_id(res_id),
    .busy(busy), .match_cnt(match_cnt)
  );

  cmp_eq_rr_arbiter #(.N(N), .W(W), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .ack(s_ack),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_eq(s_res_eq), .res_id(s_res_id),
    .busy(s_busy), .match_cnt(s_match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       eq;
    logic [1:0] id;
  } res_t;

  res_t         exp_q [$];
  logic [N-1:0] ack_log [$];
  int           ack_cyc [$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      if (ack != '0) begin
        chk("ack_onehot", 32'($onehot(ack)), 32'd1);
        ack_log.push_back(ack);
        ack_cyc.push_back(cyc);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(res_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_eq", 32'(res_eq), 32'(e.eq));
          chk("res_id", 32'(res_id), 32'(e.id));
        end
      end
    end
  end

  // Requesters drop their req once they have seen their ack.
  task automatic step();
    @(posedge clk);
    #1;
    req = req & ~ack;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 60) begin
      step();
      k++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic clear_log();
    ack_log.delete();
    ack_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int k;
    req = '0;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_eq", 32'(res_eq), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // All four request at once: order 0,1,2,3, two cycles apart.
    clear_log();
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_op[i] = 32'h1000_0000 + 32'(i);
      b_op[i] = 32'h1000_0000 + 32'(i);
      exp_q.push_back('{eq: 1'b1, id: 2'(i)});
    end
    req = 4'b1111;
    drain("fair");
    chk("fair_grants", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("fair_order", 32'(ack_log[i]), 32'd1 << i);
      for (int i = 1; i < 4; i++) chk("fair_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);
    end
    chk("fair_cnt", 32'(match_cnt), 32'd4);

    // Single request, full latency walk.
    a_op[0] = 32'hDEAD_BEEF;
    b_op[0] = 32'hDEAD_BEEF;
    req = 4'b0001;
    exp_q.push_back('{eq: 1'b1, id: 2'd0});
    step();
    chk("single_ack", 32'(ack), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_no_valid_yet", 32'(res_valid), 32'd0);
    step();
    chk("single_ack_pulse", 32'(ack), 32'd0);
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_eq", 32'(res_eq), 32'd1);
    drain("single");
    chk("single_cnt", 32'(match_cnt), 32'd5);

    // Five matches so far: the 2-bit counter sits at all-ones.
    chk("sat_cnt", 32'(s_match_cnt), 32'd3);
    chk("sat_ack", 32'(s_ack), 32'd0);
    chk("sat_valid", 32'(s_res_valid), 32'd0);
    chk("sat_busy", 32'(s_busy), 32'd0);
    chk("sat_eq", 32'(s_res_eq), 32'd1);
    chk("sat_id", 32'(s_res_id), 32'd0);

    // Only the top bit differs.
    a_op[2] = 32'h8000_0000;
    b_op[2] = 32'h0000_0000;
    req = 4'b0100;
    exp_q.push_back('{eq: 1'b0, id: 2'd2});
    drain("mismatch");
    chk("mismatch_cnt", 32'(match_cnt), 32'd5);

    // Last grant was 2, so 3 goes before 0.
    clear_log();
    a_op[3] = 32'h5A5A_5A5A;
    b_op[3] = 32'h5A5A_5A5A;
    a_op[0] = 32'h0000_0001;
    b_op[0] = 32'h0000_0000;
    req = 4'b1001;
    exp_q.push_back('{eq: 1'b1, id: 2'd3});
    exp_q.push_back('{eq: 1'b0, id: 2'd0});
    drain("rot");
    chk("rot_grants", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      chk("rot_first", 32'(ack_log[0]), 32'd8);
      chk("rot_second", 32'(ack_log[1]), 32'd1);
    end
    chk("rot_cnt", 32'(match_cnt), 32'd6);

    // Backpressure: result held, pending req waits for the accepting edge.
    a_op[0] = 32'hCAFE_F00D;
    b_op[0] = 32'hCAFE_F00D;
    a_op[1] = 32'd7;
    b_op[1] = 32'd6;
    res_ready = 1'b0;
    req = 4'b0001;
    exp_q.push_back('{eq: 1'b1, id: 2'd0});
    k = 0;
    while (!res_valid && k < 10) begin
      step();
      k++;
    end
    chk("bp_valid", 32'(res_valid), 32'd1);
    req = 4'b0010;
    exp_q.push_back('{eq: 1'b0, id: 2'd1});
    repeat (5) begin
      step();
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_eq", 32'(res_eq), 32'd1);
      chk("bp_hold_id", 32'(res_id), 32'd0);
      chk("bp_no_ack", 32'(ack), 32'd0);
    end
    res_ready = 1'b1;
    step();
    chk("bp_ack", 32'(ack), 32'd2);
    drain("bp");
    chk("bp_cnt", 32'(match_cnt), 32'd7);

    // Reset while comparing: transaction discarded.
    a_op[0] = 32'd1;
    b_op[0] = 32'd1;
    req = 4'b0001;
    step();
    chk("rstmid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ack", 32'(ack), 32'd0);
    chk("rstmid_valid", 32'(res_valid), 32'd0);
    chk("rstmid_eq", 32'(res_eq), 32'd0);
    chk("rstmid_id", 32'(res_id), 32'd0);
    chk("rstmid_busy0", 32'(busy), 32'd0);
    chk("rstmid_cnt", 32'(match_cnt), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    req = '0;
    repeat (6) begin
      step();
      chk("post_rst_valid", 32'(res_valid), 32'd0);
      chk("post_rst_ack", 32'(ack), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
